// File: rtl/bist_transmitter.sv
// BIST pattern transmitter: drives a 32-bit LFSR-derived shifting pattern onto
// the link in lockstep with the far-end receiver, then hands the link over to
// functional traffic once the programmed number of words has been sent.

// 32-bit Fibonacci LFSR, taps 32/22/2/1. Must match the receiver's generator.
module lfsr32 #(
   parameter logic [31:0] SEED = 32'hdeadbeef
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] rng
);

   logic [31:0] lfsr_q, lfsr_d;

   // next state: shift left, feedback from the tap parity
   always_comb lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

   // free-running state register, reloads SEED on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr_q <= SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign rng = lfsr_q;

endmodule

module bist_transmitter #(
   parameter int unsigned TEST_CHANNELS = 70,
   parameter logic [31:0] SEED          = 32'hdeadbeef,
   parameter logic [31:0] TEST_CASES    = 32'd1000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     abort,
   input  logic                     inject_error,
   input  logic [TEST_CHANNELS-1:0] func_channels,
   output logic [TEST_CHANNELS-1:0] output_channels,
   output logic                     busy,
   output logic                     done,
   output logic                     aborted,
   output logic [31:0]              sent_count
);

   typedef enum logic [1:0] {S_RUN, S_DONE, S_ABORTED} state_e;

   state_e                   state_q;
   logic [TEST_CHANNELS-1:0] pattern_q, pattern_d;
   logic [31:0]              sent_q;
   logic                     err_q;
   logic                     busy_q, done_q, aborted_q;
   logic [31:0]              rng;
   logic [32:0]              next_cnt;
   logic                     last_word;

   lfsr32 #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .rng   (rng)
   );

   // New word = old pattern shifted up by 32 with the fresh rng in the low bits.
   if (TEST_CHANNELS > 32) begin : g_wide
      assign pattern_d = {pattern_q[TEST_CHANNELS-33:0], rng};
   end else begin : g_narrow
      assign pattern_d = rng[TEST_CHANNELS-1:0];
   end

   // 33-bit compare so TEST_CASES == 0 terminates on the first edge and the
   // counter saturates at TEST_CASES instead of wrapping.
   assign next_cnt  = {1'b0, sent_q} + 33'd1;
   assign last_word = next_cnt >= {1'b0, TEST_CASES};

   // Control FSM with registered status flags; DONE and ABORTED are terminal.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_RUN;
         pattern_q <= '0;
         sent_q    <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         err_q <= inject_error & (state_q == S_RUN);
         if (state_q == S_RUN) begin
            pattern_q <= pattern_d;
            sent_q    <= last_word ? TEST_CASES : next_cnt[31:0];
            // abort takes priority over normal completion
            if (abort) begin
               state_q   <= S_ABORTED;
               busy_q    <= 1'b0;
               aborted_q <= 1'b1;
            end else if (last_word) begin
               state_q <= S_DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
         end
      end
   end

   // Link mux: registered pattern (bit 0 optionally corrupted), functional
   // pass-through after completion, or quiet after abort.
   always_comb begin
      output_channels = '0;
      case (state_q)
         S_RUN:   output_channels = pattern_q ^ TEST_CHANNELS'(err_q);
         S_DONE:  output_channels = func_channels;
         default: output_channels = '0;
      endcase
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign aborted    = aborted_q;
   assign sent_count = sent_q;

endmodule

// File: tb/tb_bist_transmitter.sv
// Bench for bist_transmitter: scenario table (abort/inject points with expected
// end state) run against a cycle model, plus hand sequences for word
// constants, mid-run reset replay and TEST_CASES of 1 and 0.
module tb_bist_transmitter;

   localparam int          W    = 70;
   localparam int          TC   = 1000;
   localparam logic [31:0] SEED = 32'hdeadbeef;

   logic          clk = 1'b0;
   logic          reset;
   logic          abort;
   logic          inject_error;
   logic [W-1:0]  func_channels;
   logic [W-1:0]  output_channels, out1, out0;
   logic          busy, done, aborted;
   logic          busy1, done1, ab1, busy0, done0, ab0;
   logic [31:0]   sent_count, sent1, sent0;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] ref_words [0:319];

   always #5 clk = ~clk;

   bist_transmitter #(.TEST_CHANNELS(W), .SEED(SEED), .TEST_CASES(32'd1000)) u_dut (
      .clk(clk), .reset(reset), .abort(abort), .inject_error(inject_error),
      .func_channels(func_channels), .output_channels(output_channels),
      .busy(busy), .done(done), .aborted(aborted), .sent_count(sent_count));

   bist_transmitter #(.TEST_CHANNELS(W), .SEED(SEED), .TEST_CASES(32'd1)) u_tc1 (
      .clk(clk), .reset(reset), .abort(abort), .inject_error(inject_error),
      .func_channels(func_channels), .output_channels(out1),
      .busy(busy1), .done(done1), .aborted(ab1), .sent_count(sent1));

   bist_transmitter #(.TEST_CHANNELS(W), .SEED(SEED), .TEST_CASES(32'd0)) u_tc0 (
      .clk(clk), .reset(reset), .abort(abort), .inject_error(inject_error),
      .func_channels(func_channels), .output_channels(out0),
      .busy(busy0), .done(done0), .aborted(ab0), .sent_count(sent0));

   typedef struct {
      string name;
      int    abort_at;
      int    inject_at;
      logic  exp_done;
      logic  exp_aborted;
      int    exp_sent;
   } scn_t;

   scn_t scn [5];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] lfsr_next(input logic [31:0] q);
      return {q[30:0], ^(q & 32'h8020_0003)};
   endfunction

   task automatic run_scn(input scn_t s, input bit capture);
      logic [31:0] m_lfsr;
      logic [W-1:0] m_pat, exp_o;
      logic [2:0]  exp_f;
      logic        m_err;
      int          m_st, m_sent, mism;
      reset = 1'b1; abort = 1'b0; inject_error = 1'b0;
      repeat (2) @(negedge clk);
      chk({s.name, " reset_out"}, output_channels, '0);
      chk({s.name, " reset_flags"}, W'({busy, done, aborted}), W'(3'b100));
      chk({s.name, " reset_sent"}, W'(sent_count), '0);
      reset = 1'b0;
      m_lfsr = SEED; m_pat = '0; m_err = 1'b0; m_st = 0; m_sent = 0; mism = 0;
      for (int k = 0; k < TC + 10; k++) begin
         case (m_st)
            0:       begin exp_o = m_pat ^ W'(m_err); exp_f = 3'b100; end
            1:       begin exp_o = func_channels;     exp_f = 3'b010; end
            default: begin exp_o = '0;                exp_f = 3'b001; end
         endcase
         if (output_channels !== exp_o || {busy, done, aborted} !== exp_f ||
             sent_count !== 32'(m_sent))
            mism++;
         if (capture && k < 320) ref_words[k] = output_channels;
         if (capture && k == 0) chk("word0", output_channels, '0);
         if (capture && k == 1) chk("word1", output_channels, 70'hdeadbeef);
         if (capture && k == 2) chk("word2", output_channels, 70'h00deadbeefbd5b7dde);
         if (s.inject_at >= 0 && k == s.inject_at + 1 && m_st == 0)
            chk({s.name, " err_bit0_only"}, output_channels ^ m_pat, W'(1));
         abort        = (k == s.abort_at);
         inject_error = (k == s.inject_at);
         @(posedge clk);
         m_err = inject_error & (m_st == 0);
         if (m_st == 0) begin
            m_pat = (m_pat << 32) | W'(m_lfsr);
            if (m_sent < TC) m_sent++;
            if (abort)             m_st = 2;
            else if (m_sent >= TC) m_st = 1;
         end
         m_lfsr = lfsr_next(m_lfsr);
         @(negedge clk);
      end
      abort = 1'b0; inject_error = 1'b0;
      chk({s.name, " stream"}, W'(mism), '0);
      chk({s.name, " done"}, W'(done), W'(s.exp_done));
      chk({s.name, " aborted"}, W'(aborted), W'(s.exp_aborted));
      chk({s.name, " busy"}, W'(busy), '0);
      chk({s.name, " sent"}, W'(sent_count), W'(s.exp_sent));
      chk({s.name, " link"}, output_channels, s.exp_done ? 70'h15 : 70'h0);
   endtask

   initial begin
      int mism;
      func_channels = 70'h15;
      reset = 1'b1; abort = 1'b0; inject_error = 1'b0;

      scn[0] = '{"clean",     -1,  -1, 1'b1, 1'b0, 1000};
      scn[1] = '{"inject500", -1, 500, 1'b1, 1'b0, 1000};
      scn[2] = '{"abort200", 200,  -1, 1'b0, 1'b1,  201};
      scn[3] = '{"abort999", 999,  -1, 1'b0, 1'b1, 1000};
      scn[4] = '{"inject999", -1, 999, 1'b1, 1'b0, 1000};

      for (int i = 0; i < 5; i++) run_scn(scn[i], i == 0);

      // mid-run reset: hold 3 cycles, then replay must match the clean run
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (300) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midreset_out", output_channels, '0);
      chk("midreset_sent", W'(sent_count), '0);
      chk("midreset_busy", W'({busy, done, aborted}), W'(3'b100));
      repeat (3) @(negedge clk);
      chk("midreset_hold_out", output_channels, '0);
      reset = 1'b0;
      mism = 0;
      for (int k = 0; k < 320; k++) begin
         if (output_channels !== ref_words[k]) mism++;
         @(negedge clk);
      end
      chk("replay", W'(mism), '0);

      // TEST_CASES = 1 and 0 instances
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("tc1_pre_busy", W'({busy1, done1, ab1}), W'(3'b100));
      chk("tc1_pre_out", out1, '0);
      chk("tc0_pre_out", out0, '0);
      @(negedge clk);
      chk("tc1_flags", W'({busy1, done1, ab1}), W'(3'b010));
      chk("tc1_sent", W'(sent1), W'(1));
      chk("tc1_link", out1, 70'h15);
      chk("tc0_flags", W'({busy0, done0, ab0}), W'(3'b010));
      chk("tc0_sent", W'(sent0), '0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("tc1_abort_ignored", W'({busy1, done1, ab1}), W'(3'b010));
      chk("tc1_sent_hold", W'(sent1), W'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
